// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes a MIPS ALU instruction, issues registered operands
// to an external combinational ALU, captures its result and presents it on a
// valid/ready response port.
// Optional feature macro: ALU_ISSUE_B2B_EN (accept a new request in the same
// cycle the pending response is consumed, one result every two cycles).
module alu_issue_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_illegal_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] imm_ext;

  logic        dec_legal;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_src1;
  logic [31:0] dec_src2;

  logic        accept;
  logic        rsp_done;

  assign opcode  = instr_i[31:26];
  assign funct   = instr_i[5:0];
  assign shamt   = instr_i[10:6];
  assign imm_ext = {{16{instr_i[15]}}, instr_i[15:0]};

  // Register-number fields are resolved upstream; only the data arrives here.
  logic unused_fields;
  assign unused_fields = &{1'b0, instr_i[25:16]};

  assign accept   = req_valid_i & req_ready_o;
  assign rsp_done = rsp_valid_o & rsp_ready_i;

  // Instruction decode: ALU op code, operand selection and legality
  always_comb begin
    dec_legal = 1'b1;
    dec_ctrl  = 4'd0;
    dec_src1  = rs_data_i;
    dec_src2  = rt_data_i;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h24: dec_ctrl = 4'd0;
          6'h25: dec_ctrl = 4'd1;
          6'h20: dec_ctrl = 4'd2;
          6'h2A: dec_ctrl = 4'd4;
          6'h22: dec_ctrl = 4'd6;
          6'h03: begin
            // Shift amount travels in the src1 bit positions it occupies in the instruction
            dec_ctrl = 4'd8;
            dec_src1 = {21'b0, shamt, 6'b0};
          end
          6'h07: dec_ctrl = 4'd9;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_ctrl = 4'd2;  dec_src2 = imm_ext; end
      6'h0A: begin dec_ctrl = 4'd3;  dec_src2 = imm_ext; end
      6'h0F: begin dec_ctrl = 4'd11; dec_src2 = imm_ext; end
      6'h04: dec_ctrl = 4'd7;
      6'h05: dec_ctrl = 4'd10;
      default: dec_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; an illegal request bypasses EXEC
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = dec_legal ? EXEC : RESP;
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_done) begin
          // accept can only be high here when back-to-back issue is enabled
          if (accept) state_next = dec_legal ? EXEC : RESP;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_reg)
      IDLE: req_ready_o = 1'b1;
      RESP: begin
        rsp_valid_o = 1'b1;
`ifdef ALU_ISSUE_B2B_EN
        req_ready_o = rsp_ready_i;
`else
        req_ready_o = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // ALU operand registers: loaded only by an accepted legal request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_src1_o <= 32'd0;
      alu_src2_o <= 32'd0;
      alu_ctrl_o <= 4'd0;
    end else if (accept && dec_legal) begin
      alu_src1_o <= dec_src1;
      alu_src2_o <= dec_src2;
      alu_ctrl_o <= dec_ctrl;
    end
  end

  // Response registers: illegal result at accept, ALU result at end of EXEC
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_result_o  <= 32'd0;
      rsp_zero_o    <= 1'b0;
      rsp_illegal_o <= 1'b0;
    end else if (accept && !dec_legal) begin
      rsp_result_o  <= 32'd0;
      rsp_zero_o    <= 1'b0;
      rsp_illegal_o <= 1'b1;
    end else if (state_reg == EXEC) begin
      rsp_result_o  <= alu_result_i;
      rsp_zero_o    <= alu_zero_i;
      rsp_illegal_o <= 1'b0;
    end
  end

endmodule
